// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the CNN input memory controller
// Contents:
//   state_e          : controller FSM states
//   RD_LATENCY_DEF   : default memory read latency (cycles)
//   DRAIN_CYCLES_DEF : default settle time after a row load (cycles)
package cnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_READ,
      ST_DONE
   } state_e;

   localparam int RD_LATENCY_DEF   = 1;
   localparam int DRAIN_CYCLES_DEF = 8;

endpackage

// File: rtl/cnn_input_mem_ctrl_if.sv
// rtl/cnn_input_mem_ctrl_if.sv - row stream, memory port and window bus bundle
// Signals:
//   i_s_valid/i_s_data/o_s_ready : incoming row-data stream
//   o_mem_*                      : line-buffer memory enables, addresses, write data
//   o_win_valid/o_win_col        : window column valid at memory read output
// Modports: master = controller side, slave = stream source / memory side.
interface cnn_input_mem_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);

   logic                  i_s_valid;
   logic [DATA_WIDTH-1:0] i_s_data;
   logic                  o_s_ready;
   logic                  o_mem_bram_en;
   logic                  o_mem_wenable;
   logic                  o_mem_renable;
   logic [ADDR_WIDTH-1:0] o_mem_waddress;
   logic [ADDR_WIDTH-1:0] o_mem_raddress;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic                  o_win_valid;
   logic [ADDR_WIDTH-1:0] o_win_col;

   modport master (
      input  i_s_valid, i_s_data,
      output o_s_ready, o_mem_bram_en, o_mem_wenable, o_mem_renable,
             o_mem_waddress, o_mem_raddress, o_mem_wdata, o_win_valid, o_win_col
   );

   modport slave (
      output i_s_valid, i_s_data,
      input  o_s_ready, o_mem_bram_en, o_mem_wenable, o_mem_renable,
             o_mem_waddress, o_mem_raddress, o_mem_wdata, o_win_valid, o_win_col
   );

endinterface

// File: rtl/cnn_delay_line.sv
// rtl/cnn_delay_line.sv - resettable fixed-latency delay line
// Ports:
//   i_clock, i_reset (sync, active-low)
//   i_data : WIDTH-bit input
//   o_data : i_data delayed by LATENCY cycles (LATENCY=0 is a wire)
module cnn_delay_line #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (LATENCY == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = i_clock ^ i_reset;
         assign o_data = i_data;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe_q [LATENCY];

         always_ff @(posedge i_clock) begin
            if (!i_reset) begin
               for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= i_data;
               for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign o_data = pipe_q[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/cnn_input_mem_ctrl.sv
// rtl/cnn_input_mem_ctrl.sv - line-buffer loader/reader for a CNN input frame
// Ports:
//   i_clock, i_reset (sync, active-low)
//   i_start      : frame start pulse (honoured only in IDLE)
//   i_num_rows   : rows in the frame, latched at start
//   bus          : row stream in, memory port and window outputs (master modport)
//   o_row_done   : one-cycle pulse with the last window column of a row sweep
//   o_frame_done : one-cycle pulse when the frame completes
//   o_busy       : controller not IDLE
module cnn_input_mem_ctrl
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 12,
   parameter int ROW_LEN         = 32,
   parameter int KERNEL_ROW_SIZE = 3,
   parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEF,
   parameter int RD_LATENCY      = RD_LATENCY_DEF
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [15:0]          i_num_rows,
   cnn_input_mem_ctrl_if.master bus,
   output logic                 o_row_done,
   output logic                 o_frame_done,
   output logic                 o_busy
);

   localparam int                    DCW        = $clog2(DRAIN_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(ROW_LEN - 1);
   localparam logic [DCW-1:0]        LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);
   localparam logic [15:0]           KROWS      = 16'(KERNEL_ROW_SIZE);

   state_e                state_q, state_d;
   logic [15:0]           num_rows_q, num_rows_d;
   logic [15:0]           rows_loaded_q, rows_loaded_d;
   logic [ADDR_WIDTH-1:0] word_q, word_d;
   logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
   logic                  rd_issued_q, rd_issued_d;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  handshake;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH:0]   win_bus;
   logic                  win_valid;
   logic [ADDR_WIDTH-1:0] win_col;

   assign handshake = bus.i_s_valid && (state_q == ST_LOAD);
   // word_q doubles as the read address; rd_issued_q stops issue once the
   // whole row is out while the read pipeline is still delivering data.
   assign rd_en     = (state_q == ST_READ) && !rd_issued_q;
   assign rd_addr   = rd_en ? word_q : '0;

   cnn_delay_line #(
      .WIDTH   (ADDR_WIDTH + 1),
      .LATENCY (RD_LATENCY)
   ) u_win_delay (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_data  ({rd_en, rd_addr}),
      .o_data  (win_bus)
   );

   assign win_valid = win_bus[ADDR_WIDTH];
   assign win_col   = win_bus[ADDR_WIDTH-1:0];
   assign o_row_done = win_valid && (win_col == LAST_WORD);

   always_comb begin
      state_d       = state_q;
      num_rows_d    = num_rows_q;
      rows_loaded_d = rows_loaded_q;
      word_d        = word_q;
      drain_cnt_d   = drain_cnt_q;
      rd_issued_d   = rd_issued_q;
      wen_d         = 1'b0;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               num_rows_d    = i_num_rows;
               rows_loaded_d = '0;
               word_d        = '0;
               state_d       = (i_num_rows == 16'd0) ? ST_DONE : ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (handshake) begin
               wen_d   = 1'b1;
               waddr_d = word_q;
               wdata_d = bus.i_s_data;
               if (word_q == LAST_WORD) begin
                  word_d        = '0;
                  rows_loaded_d = rows_loaded_q + 16'd1;
                  drain_cnt_d   = '0;
                  state_d       = ST_DRAIN;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            if (drain_cnt_q == LAST_DRAIN) begin
               drain_cnt_d = '0;
               word_d      = '0;
               rd_issued_d = 1'b0;
               if (rows_loaded_q >= KROWS)            state_d = ST_READ;
               else if (rows_loaded_q == num_rows_q)  state_d = ST_DONE;
               else                                   state_d = ST_LOAD;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end

         ST_READ: begin
            if (rd_en) begin
               if (word_q == LAST_WORD) begin
                  word_d      = '0;
                  rd_issued_d = 1'b1;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
            if (o_row_done) begin
               word_d      = '0;
               rd_issued_d = 1'b0;
               state_d     = (rows_loaded_q == num_rows_q) ? ST_DONE : ST_LOAD;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q       <= ST_IDLE;
         num_rows_q    <= '0;
         rows_loaded_q <= '0;
         word_q        <= '0;
         drain_cnt_q   <= '0;
         rd_issued_q   <= 1'b0;
         wen_q         <= 1'b0;
         waddr_q       <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         num_rows_q    <= num_rows_d;
         rows_loaded_q <= rows_loaded_d;
         word_q        <= word_d;
         drain_cnt_q   <= drain_cnt_d;
         rd_issued_q   <= rd_issued_d;
         wen_q         <= wen_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
      end
   end

   assign bus.o_s_ready      = (state_q == ST_LOAD);
   assign bus.o_mem_bram_en  = (state_q != ST_IDLE);
   assign bus.o_mem_wenable  = wen_q;
   assign bus.o_mem_waddress = waddr_q;
   assign bus.o_mem_wdata    = wdata_q;
   assign bus.o_mem_renable  = rd_en;
   assign bus.o_mem_raddress = rd_addr;
   assign bus.o_win_valid    = win_valid;
   assign bus.o_win_col      = win_col;
   assign o_frame_done       = (state_q == ST_DONE);
   assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cnn_input_mem_ctrl.sv
// tb/tb_cnn_input_mem_ctrl.sv - self-checking bench for cnn_input_mem_ctrl
module tb_cnn_input_mem_ctrl;
   import cnn_pkg::*;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int RL = 32;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_num_rows = '0;
   logic        o_row_done, o_frame_done, o_busy;

   cnn_input_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   cnn_input_mem_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN(RL), .KERNEL_ROW_SIZE(3),
      .DRAIN_CYCLES(8), .RD_LATENCY(1)
   ) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_num_rows   (i_num_rows),
      .bus          (bus),
      .o_row_done   (o_row_done),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy)
   );

   always #5 i_clock = ~i_clock;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int nrows;
      int gap_at;
      int gap_len;
      int exp_wr;
      int exp_rd;
      int exp_rdn;
   } vec_t;

   wr_t  sb_q[$];
   wr_t  w;
   int   n_tests = 0, n_fail = 0;
   int   n_wr, n_rd, n_rdn, n_fd, n_ready;
   logic prev_ren;
   logic [AW-1:0] prev_raddr;
   int   exp_raddr;
   vec_t vecs[7];

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"},  bus.o_s_ready, 0);
      check({tag, "_bram_en"},  bus.o_mem_bram_en, 0);
      check({tag, "_wen"},      bus.o_mem_wenable, 0);
      check({tag, "_ren"},      bus.o_mem_renable, 0);
      check({tag, "_waddr"},    bus.o_mem_waddress, 0);
      check({tag, "_raddr"},    bus.o_mem_raddress, 0);
      check({tag, "_wdata"},    bus.o_mem_wdata, 0);
      check({tag, "_win_v"},    bus.o_win_valid, 0);
      check({tag, "_win_col"},  bus.o_win_col, 0);
      check({tag, "_row_done"}, o_row_done, 0);
      check({tag, "_frame_dn"}, o_frame_done, 0);
      check({tag, "_busy"},     o_busy, 0);
   endtask

   // Output monitor: scoreboard pops for writes, read-address sequence and
   // a one-cycle model of the read-latency pipeline.
   initial begin
      prev_ren = 1'b0; prev_raddr = '0; exp_raddr = 0;
      n_wr = 0; n_rd = 0; n_rdn = 0; n_fd = 0; n_ready = 0;
      forever begin
         @(posedge i_clock);
         #1;
         if (!i_reset) begin
            prev_ren = 1'b0; prev_raddr = '0; exp_raddr = 0;
         end else begin
            if (bus.o_s_ready) n_ready++;
            if (bus.o_mem_wenable) begin
               n_wr++;
               if (sb_q.size() == 0) check("wr_unexpected", 1, 0);
               else begin
                  w = sb_q.pop_front();
                  check("waddr", bus.o_mem_waddress, w.addr);
                  check("wdata", bus.o_mem_wdata, w.data);
               end
            end
            if (bus.o_mem_renable) begin
               n_rd++;
               check("raddr", bus.o_mem_raddress, exp_raddr);
               exp_raddr = (exp_raddr + 1) % RL;
            end
            if (prev_ren && prev_raddr != AW'(RL - 1)) check("rd_gap", bus.o_mem_renable, 1);
            check("win_valid", bus.o_win_valid, prev_ren);
            if (prev_ren) check("win_col", bus.o_win_col, prev_raddr);
            check("row_done", o_row_done, prev_ren && (prev_raddr == AW'(RL - 1)));
            if (o_row_done) n_rdn++;
            if (o_frame_done) n_fd++;
            prev_ren   = bus.o_mem_renable;
            prev_raddr = bus.o_mem_raddress;
         end
      end
   end

   task automatic run_frame(input int n, input int gap_at, input int gap_len,
                            input int abort_rd, output bit aborted);
      int word = 0, total = 0, gap_left = gap_len, cyc = 0;
      bit gap_prev = 0;
      aborted = 0;
      sb_q.delete();
      n_wr = 0; n_rd = 0; n_rdn = 0; n_fd = 0; n_ready = 0;
      @(negedge i_clock);
      i_start = 1'b1; i_num_rows = 16'(n);
      @(negedge i_clock);
      i_start = 1'b0;
      while (n_fd == 0 && cyc < 4000) begin
         if (gap_prev) begin
            check("gap_wen", bus.o_mem_wenable, 0);
            check("gap_waddr_hold", bus.o_mem_waddress, gap_at - 1);
         end
         gap_prev = 0;
         if (abort_rd >= 0 && bus.o_mem_renable && bus.o_mem_raddress == AW'(abort_rd)) begin
            i_reset = 1'b0;
            bus.i_s_valid = 1'b0;
            @(negedge i_clock);
            check_all_zero("abort");
            i_reset = 1'b1;
            aborted = 1;
            return;
         end
         // a start pulse mid-frame with a different row count must be ignored
         i_start = (cyc == 20);
         if (cyc == 20) i_num_rows = 16'(n + 1);
         if (bus.o_s_ready) begin
            if (total == gap_at && gap_left > 0) begin
               bus.i_s_valid = 1'b0;
               gap_left--;
               gap_prev = 1;
            end else begin
               bus.i_s_valid = 1'b1;
               bus.i_s_data  = $urandom;
               sb_q.push_back('{addr: AW'(word), data: bus.i_s_data});
               word = (word + 1) % RL;
               total++;
            end
         end else begin
            bus.i_s_valid = 1'b0;
         end
         @(negedge i_clock);
         cyc++;
      end
      i_start = 1'b0;
      bus.i_s_valid = 1'b0;
      repeat (3) @(negedge i_clock);
   endtask

   task automatic run_and_check(input vec_t v, input string tag);
      bit ab;
      run_frame(v.nrows, v.gap_at, v.gap_len, -1, ab);
      check({tag, "_frame_done_cnt"}, n_fd, 1);
      check({tag, "_writes"},         n_wr, v.exp_wr);
      check({tag, "_reads"},          n_rd, v.exp_rd);
      check({tag, "_row_done_cnt"},   n_rdn, v.exp_rdn);
      check({tag, "_ready_cycles"},   n_ready, v.exp_wr + v.gap_len);
      check({tag, "_sb_leftover"},    sb_q.size(), 0);
      check({tag, "_idle_after"},     o_busy, 0);
   endtask

   initial begin
      bit ab;
      vecs[0] = '{3, -1, 0,  96, 32, 1};
      vecs[1] = '{3, 10, 5,  96, 32, 1};
      vecs[2] = '{2, -1, 0,  64,  0, 0};
      vecs[3] = '{0, -1, 0,   0,  0, 0};
      vecs[4] = '{5, -1, 0, 160, 96, 3};
      vecs[5] = '{1, -1, 0,  32,  0, 0};
      vecs[6] = '{4, 31, 3, 128, 64, 2};

      bus.i_s_valid = 1'b0;
      bus.i_s_data  = '0;
      repeat (3) @(negedge i_clock);
      check_all_zero("reset");
      i_reset = 1'b1;
      @(negedge i_clock);

      for (int i = 0; i < 7; i++) run_and_check(vecs[i], $sformatf("vec%0d", i));

      // zero-row frame: DONE straight after the start edge, one pulse only
      @(negedge i_clock);
      i_start = 1'b1; i_num_rows = 16'd0;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      check("zero_rows_fd_now", o_frame_done, 1);
      check("zero_rows_ready",  bus.o_s_ready, 0);
      @(posedge i_clock); #1;
      check("zero_rows_fd_gone", o_frame_done, 0);
      check("zero_rows_idle",    o_busy, 0);

      // reset while reading column 15, then a normal frame afterwards
      run_frame(3, -1, 0, 15, ab);
      check("abort_taken", ab, 1);
      repeat (5) @(negedge i_clock);
      check("abort_no_frame_done", n_fd, 0);
      check("abort_idle", o_busy, 0);
      run_and_check(vecs[0], "post_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
